seq_serializer: RTL and testbench
=================================

# seq_serializer

Parallel-to-serial front end for the serial sequence detectors. Accepts WIDTH-bit words over a valid/ready handshake, double-buffers them (shifter plus one holding register), and emits one bit per clock on `ser_out`, which drives a detector's `in_seq` input directly. Back-to-back words stream with no idle bit between them, so patterns that span word boundaries remain detectable.

## Interface
- `WIDTH`, default 8: word width in bits, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `data_in`  in  WIDTH  parallel word.
- `msb_first`  in  1  bit order of the word offered on `data_in`. 1 = bit WIDTH-1 first. Sampled with the word.
- `load_valid`  in  1  `data_in` and `msb_first` are valid.
- `load_ready`  out  1  the block can accept a word this cycle.
- `shift_en`  in  1  advance the serial stream by one bit. Tie high when feeding a detector.
- `ser_out`  out  1  current serial bit. Forced to 0 when `ser_valid` = 0.
- `ser_valid`  out  1  the shifter holds a word being transmitted.
- `word_done`  out  1  high while the last bit of the current word is on `ser_out`.
- `busy`  out  1  `ser_valid` OR holding register occupied.

## Operation
- Reset value when `rst` = 0, effective immediately regardless of clock:
  - shifter, holding register, bit counter and stored order flags all 0.
  - `ser_valid` = 0, `ser_out` = 0, `word_done` = 0, `busy` = 0, `load_ready` = 1.
- A handshake occurs on a rising edge with `load_valid` = 1 and `load_ready` = 1. `load_ready` = NOT hold_full; it is a function of registers only.
- State machine:
  - IDLE (`ser_valid` = 0): a handshake loads the word and `msb_first` straight into the shifter, clears the counter, and moves to SHIFT.
  - SHIFT (`ser_valid` = 1): each edge with `shift_en` = 1 advances one bit and increments the counter (0 to WIDTH-1).
  - SHIFT end of word: on the edge that advances past bit WIDTH-1 (counter = WIDTH-1, `shift_en` = 1):
    - if the holding register is full, it is moved into the shifter, the counter is cleared, the state stays SHIFT, and the holding register is freed;
    - else if a handshake occurs on the same edge, the new word goes directly into the shifter and the state stays SHIFT;
    - else the state returns to IDLE.
  - SHIFT, not at end of word: a handshake stores the word plus order flag in the holding register (hold_full = 1).
- `ser_out`:
  - MSB-first words present bit WIDTH-1-count.
  - LSB-first words present bit count.
- `word_done` = `ser_valid` AND (count = WIDTH-1).
- Stall (`shift_en` = 0): `ser_out`, `ser_valid`, `word_done` and the counter hold; handshakes into an empty holding register are still accepted.
- The holding register never holds more than one word. A handshake is impossible while it is full.
- Reset asserted mid-word discards the shifter and holding contents; no partial word is resumed.

## Timing
- Latency: a handshake at edge N in IDLE puts the first bit on `ser_out` after edge N. `ser_valid` = 1 in cycle N+1.
- Throughput: one bit per clock with `shift_en` = 1, continuous across words when each next word is handshaken no later than the last-bit edge of the current word.
- `load_ready` deasserts the cycle after the holding register fills. It reasserts the cycle after the shifter reloads from it.
- All outputs are decoded from registers; there is no combinational path from any input to any output.

## Test plan
- Reset: hold `rst` = 0 over several clocks, then release. Required: `ser_valid` = 0, `ser_out` = 0, `load_ready` = 1, `busy` = 0, and these values appear even when `rst` falls between clock edges.
- Single word, WIDTH = 8, `data_in` = 8'hE8, `msb_first` = 1, `shift_en` = 1. Required:
  - `ser_out` = 1,1,1,0,1,0,0,0 on consecutive cycles;
  - `word_done` is high only on the 8th bit;
  - IDLE follows.
  - Chained into the 111010 Mealy detector, `det_out` = 1 while bit 6 is presented.
- Back-to-back: 8'hF0 then 8'h0F, LSB-first; the second word is handshaken while the first is shifting. Required:
  - 16 contiguous valid bits: 0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0;
  - `load_ready` = 0 while the holding register is full.
- Boundary handshake: hold empty, new word offered exactly on the last-bit edge. Required: the next word's bit 0 follows with no gap, and `ser_valid` stays 1.
- Stall: `shift_en` = 0 for 3 cycles at bit 3 of 8'hA5. Required: `ser_out` is frozen for those 3 cycles, and the sequence then resumes at bit 4 with no lost or duplicated bit.
- Mid-word reset: `rst` pulsed low during bit 5 with the holding register full. Required: all outputs return to their reset values, and the next accepted word starts from bit 0.

Source files
------------

// File: rtl/seq_serializer_if.sv
// Handshake and serial-stream bundle between a word producer and seq_serializer.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             msb_first;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output data_in, msb_first, load_valid, shift_en,
    input  load_ready, ser_out, ser_valid, word_done, busy
  );

  modport slave (
    input  data_in, msb_first, load_valid, shift_en,
    output load_ready, ser_out, ser_valid, word_done, busy
  );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: shifter plus one holding register, one bit per clock,
// back-to-back words stream with no idle bit between them.
module seq_serializer #(
  parameter int WIDTH = 8
) (
  input logic             clk_i,
  input logic             rst_ni,
  seq_serializer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic {
    Idle,
    Shift
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic [WIDTH-1:0] holdData_q, holdData_d;
  logic             holdFull_q, holdFull_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] loadWord;
  logic             handshake;
  logic             lastBit;
  logic             serValid;

  // Words are normalised to LSB-first on capture, so the bit order needs no storage
  // and the shifter is always read at the bit counter.
  always_comb begin
    loadWord = '0;
    for (int i = 0; i < WIDTH; i++) begin
      loadWord[i] = bus.msb_first ? bus.data_in[WIDTH-1-i] : bus.data_in[i];
    end
  end

  assign handshake = bus.load_valid & ~holdFull_q;
  assign serValid  = (state_q == Shift);
  assign lastBit   = serValid && (count_q == LastCount);

  assign bus.load_ready = ~holdFull_q;
  assign bus.ser_valid  = serValid;
  assign bus.ser_out    = serValid & shifter_q[count_q];
  assign bus.word_done  = lastBit;
  assign bus.busy       = serValid | holdFull_q;

  always_comb begin
    state_d    = state_q;
    shifter_d  = shifter_q;
    holdData_d = holdData_q;
    holdFull_d = holdFull_q;
    count_d    = count_q;

    case (state_q)
      Idle: begin
        if (handshake) begin
          shifter_d = loadWord;
          count_d   = '0;
          state_d   = Shift;
        end
      end

      Shift: begin
        if (bus.shift_en && lastBit) begin
          count_d = '0;
          if (holdFull_q) begin
            shifter_d  = holdData_q;
            holdFull_d = 1'b0;
          end else if (handshake) begin
            shifter_d = loadWord;
          end else begin
            state_d = Idle;
          end
        end else begin
          if (bus.shift_en) begin
            count_d = count_q + CW'(1);
          end
          // A stalled last bit is not an end-of-word edge, so the word parks in the hold register.
          if (handshake) begin
            holdData_d = loadWord;
            holdFull_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      shifter_q  <= '0;
      holdData_q <= '0;
      holdFull_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      shifter_q  <= shifter_d;
      holdData_q <= holdData_d;
      holdFull_q <= holdFull_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: reset, single word, back-to-back, boundary
// handshake, stall and mid-word reset, with hand-computed serial streams.
module tb_seq_serializer;

  logic clk;
  logic rstN;

  seq_serializer_if #(.WIDTH(8)) bus ();

  seq_serializer #(.WIDTH(8)) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (bus)
  );

  int checkCount = 0;
  int failCount  = 0;
  int cyc        = 0;
  int zeroViolations = 0;

  bit bitQ[$];
  bit doneQ[$];
  int cycQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every valid serial bit, away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.ser_valid === 1'b1) begin
      bitQ.push_back(bus.ser_out);
      doneQ.push_back(bus.word_done);
      cycQ.push_back(cyc);
    end else if (bus.ser_out !== 1'b0) begin
      zeroViolations = zeroViolations + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (actual !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Offer one word and return 1 time unit after the edge that accepted it.
  task automatic applyStimulus(input logic [7:0] word, input logic msb);
    int waitCnt;
    waitCnt = 0;
    bus.data_in    = word;
    bus.msb_first  = msb;
    bus.load_valid = 1'b1;
    while (bus.load_ready !== 1'b1 && waitCnt < 50) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    if (waitCnt >= 50) checkOutput("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
  endtask

  task automatic clearStream();
    bitQ.delete();
    doneQ.delete();
    cycQ.delete();
  endtask

  task automatic checkStream(input string tag, input logic [15:0] expBits,
                             input logic [15:0] expDone, input int n);
    checkOutput($sformatf("%s_len", tag), 32'(bitQ.size()), 32'(n));
    if (bitQ.size() == n) begin
      for (int i = 0; i < n; i++) begin
        checkOutput($sformatf("%s_bit%0d", tag, i), 32'(bitQ[i]), 32'(expBits[i]));
        checkOutput($sformatf("%s_done%0d", tag, i), 32'(doneQ[i]), 32'(expDone[i]));
      end
      checkOutput($sformatf("%s_contig", tag), 32'(cycQ[n-1] - cycQ[0]), 32'(n - 1));
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, 32'(bus.ser_valid), 32'd0);
    checkOutput({tag, "_out"}, 32'(bus.ser_out), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.word_done), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
  endtask

  initial begin
    logic [5:0] hist;
    int detIdx;

    rstN           = 1'b0;
    bus.data_in    = '0;
    bus.msb_first  = 1'b0;
    bus.load_valid = 1'b0;
    bus.shift_en   = 1'b1;

    // Reset held across several edges, then released.
    repeat (3) @(posedge clk);
    #1;
    checkIdle("rst_held");
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkIdle("rst_released");

    // Single word E8, MSB first, followed by a 111010 Mealy detector model.
    clearStream();
    applyStimulus(8'hE8, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    checkStream("single", 16'h0017, 16'h0080, 8);
    checkIdle("single_after");
    hist   = '0;
    detIdx = -1;
    for (int i = 0; i < bitQ.size(); i++) begin
      hist = {hist[4:0], bitQ[i]};
      if (hist == 6'b111010 && detIdx < 0) detIdx = i;
    end
    checkOutput("single_det_idx", 32'(detIdx), 32'd5);

    // Back-to-back F0 then 0F, LSB first; second word parks in the hold register.
    clearStream();
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h0F, 1'b0);
    checkOutput("b2b_ready_full", 32'(bus.load_ready), 32'd0);
    checkOutput("b2b_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("b2b_ready_still_full", 32'(bus.load_ready), 32'd0);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("b2b_ready_after_reload", 32'(bus.load_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    checkStream("b2b", 16'h0FF0, 16'h8080, 16);

    // Next word offered exactly on the last-bit edge with the hold register empty.
    clearStream();
    applyStimulus(8'h3C, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    applyStimulus(8'h81, 1'b0);
    checkOutput("boundary_valid", 32'(bus.ser_valid), 32'd1);
    checkOutput("boundary_ready", 32'(bus.load_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    checkStream("boundary", 16'h813C, 16'h8080, 16);

    // Three-cycle stall while bit 3 of A5 is presented.
    clearStream();
    applyStimulus(8'hA5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.shift_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.shift_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkStream("stall", 16'h0505, 16'h0400, 11);

    // Reset pulsed between edges during bit 5 with the hold register full.
    applyStimulus(8'hC3, 1'b1);
    applyStimulus(8'h5A, 1'b0);
    checkOutput("mrst_hold_full", 32'(bus.load_ready), 32'd0);
    repeat (4) @(posedge clk);
    #3;
    rstN = 1'b0;
    #1;
    checkIdle("mrst_async");
    @(posedge clk);
    #1;
    rstN = 1'b1;
    clearStream();
    applyStimulus(8'h96, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checkStream("mrst_next", 16'h0096, 16'h0080, 8);

    checkOutput("ser_out_zero_when_invalid", 32'(zeroViolations), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
